// File: rtl/life_run_controller.sv
// Front-panel sequencing for the Game of Life engine: button press decode, run/pause/step/
// clear/speed control and single-outstanding command issue. Step auto-repeat under GOL_STEP_REPEAT_EN.
module life_run_controller #(
    parameter int unsigned TICK_BASE = 1000000
`ifdef GOL_STEP_REPEAT_EN
    ,
    parameter int unsigned REPEAT_CYCLES = 4000000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_run_n,
    input  logic        btn_step_n,
    input  logic        btn_speed_n,
    input  logic        btn_clear_n,
    input  logic        cmd_done,
    output logic        cmd_start,
    output logic        cmd_op,
    output logic        busy,
    output logic        running,
    output logic [1:0]  speed,
    output logic [15:0] gen_count
);
    // state   | meaning
    // S_IDLE  | no command outstanding, waiting for a pending clear/gen
    // S_ISSUE | cmd_start pulse, cmd_op latched
    // S_BUSY  | waiting for the engine's cmd_done
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    localparam logic [31:0] TICK_BASE_W = 32'(TICK_BASE);

    state_t      state_q, state_d;
    logic [3:0]  prev_q, prev_d;
    logic        op_q, op_d;
    logic        pend_gen_q, pend_gen_d;
    logic        pend_clr_q, pend_clr_d;
    logic        running_q, running_d;
    logic [1:0]  speed_q, speed_d;
    logic [31:0] tick_q, tick_d;
    logic [15:0] gen_count_q, gen_count_d;
    logic [31:0] period;
    logic        run_press, step_press, speed_press, clear_press;

`ifdef GOL_STEP_REPEAT_EN
    localparam logic [31:0] REPEAT_W = 32'(REPEAT_CYCLES);
    logic [31:0] hold_q, hold_d;
`endif

    // prev bits reset to "pressed" so a button held through reset must be released first
    assign prev_d      = {btn_clear_n, btn_speed_n, btn_step_n, btn_run_n};
    assign run_press   = prev_q[0] & ~btn_run_n;
    assign step_press  = prev_q[1] & ~btn_step_n;
    assign speed_press = prev_q[2] & ~btn_speed_n;
    assign clear_press = prev_q[3] & ~btn_clear_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prev_q      <= 4'b0000;
            op_q        <= 1'b0;
            pend_gen_q  <= 1'b0;
            pend_clr_q  <= 1'b0;
            running_q   <= 1'b0;
            speed_q     <= 2'd0;
            tick_q      <= 32'd0;
            gen_count_q <= 16'd0;
`ifdef GOL_STEP_REPEAT_EN
            hold_q      <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            op_q        <= op_d;
            pend_gen_q  <= pend_gen_d;
            pend_clr_q  <= pend_clr_d;
            running_q   <= running_d;
            speed_q     <= speed_d;
            tick_q      <= tick_d;
            gen_count_q <= gen_count_d;
`ifdef GOL_STEP_REPEAT_EN
            hold_q      <= hold_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        pend_gen_d  = pend_gen_q;
        pend_clr_d  = pend_clr_q;
        running_d   = running_q;
        speed_d     = speed_q;
        tick_d      = tick_q;
        gen_count_d = gen_count_q;
        period      = TICK_BASE_W << (2'd3 - speed_q);

        unique case (state_q)
            S_IDLE: begin
                if (pend_clr_q || pend_gen_q) begin
                    state_d = S_ISSUE;
                    op_d    = pend_clr_q;
                    if (pend_clr_q) pend_clr_d = 1'b0;
                    else            pend_gen_d = 1'b0;
                end
            end
            S_ISSUE: state_d = S_BUSY;
            S_BUSY: begin
                if (cmd_done) begin
                    state_d     = S_IDLE;
                    gen_count_d = op_q ? 16'd0 : gen_count_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (running_q) begin
            if (tick_q == period - 32'd1) begin
                tick_d     = 32'd0;
                pend_gen_d = 1'b1;
            end else begin
                tick_d = tick_q + 32'd1;
            end
        end

        // event order within a cycle: clear, run, speed, step
        if (clear_press) begin
            pend_clr_d = 1'b1;
            running_d  = 1'b0;
            pend_gen_d = 1'b0;
            tick_d     = 32'd0;
        end else if (run_press) begin
            running_d = ~running_q;
            if (running_q) begin
                tick_d     = 32'd0;
                pend_gen_d = 1'b0;
            end
        end
        if (speed_press) begin
            speed_d = speed_q + 2'd1;
            tick_d  = 32'd0;
        end
        if (step_press && !running_d) pend_gen_d = 1'b1;

`ifdef GOL_STEP_REPEAT_EN
        hold_d = hold_q;
        if (btn_step_n || running_q) begin
            hold_d = 32'd0;
        end else if (step_press) begin
            hold_d = 32'd1;
        end else if (hold_q != 32'd0) begin
            if (hold_q == REPEAT_W) begin
                hold_d = 32'd1;
                if (!running_d) pend_gen_d = 1'b1;
            end else begin
                hold_d = hold_q + 32'd1;
            end
        end
`endif
    end

    always_comb begin
        cmd_start = (state_q == S_ISSUE);
        busy      = (state_q != S_IDLE);
        cmd_op    = op_q;
        running   = running_q;
        speed     = speed_q;
        gen_count = gen_count_q;
    end

endmodule

// File: tb/tb_life_run_controller.sv
// Scoreboard bench for life_run_controller: expected commands (op, issue cycle) are queued
// as buttons are pressed and checked when cmd_start appears; a small engine model returns cmd_done.
module tb_life_run_controller;

    logic        clk;
    logic        rst;
    logic        btn_run_n, btn_step_n, btn_speed_n, btn_clear_n;
    logic        cmd_done;
    logic        cmd_start, cmd_op, busy, running;
    logic [1:0]  speed;
    logic [15:0] gen_count;

    localparam logic [3:0] B_RUN   = 4'b0001;
    localparam logic [3:0] B_STEP  = 4'b0010;
    localparam logic [3:0] B_SPEED = 4'b0100;
    localparam logic [3:0] B_CLEAR = 4'b1000;

    typedef struct {
        logic op;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_lat = 3;
    int   done_timer = 0;

    life_run_controller #(
        .TICK_BASE(4)
`ifdef GOL_STEP_REPEAT_EN
        ,
        .REPEAT_CYCLES(10)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_run_n  (btn_run_n),
        .btn_step_n (btn_step_n),
        .btn_speed_n(btn_speed_n),
        .btn_clear_n(btn_clear_n),
        .cmd_done   (cmd_done),
        .cmd_start  (cmd_start),
        .cmd_op     (cmd_op),
        .busy       (busy),
        .running    (running),
        .speed      (speed),
        .gen_count  (gen_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic sb_push(input logic op, input int at_cyc);
        exp_t e;
        e.op  = op;
        e.cyc = at_cyc;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns the posedge at which the press is detected.
    task automatic press(input logic [3:0] m, output int edge_cyc);
        {btn_clear_n, btn_speed_n, btn_step_n, btn_run_n} = ~m;
        @(negedge clk);
        edge_cyc = cyc;
        {btn_clear_n, btn_speed_n, btn_step_n, btn_run_n} = 4'b1111;
    endtask

    // Engine model and output monitor, both on the falling edge.
    initial begin
        exp_t e;
        cmd_done = 1'b0;
        forever begin
            @(negedge clk);
            cmd_done = 1'b0;
            if (done_timer > 0) begin
                done_timer--;
                if (done_timer == 0) cmd_done = 1'b1;
            end
            if (cmd_start) begin
                done_timer = done_lat;
                chk("busy_with_start", busy, 1);
                chk("start_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("cmd_op", cmd_op, e.op);
                    chk("start_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e;
        rst = 1'b1;
        btn_run_n = 1'b1; btn_step_n = 1'b0; btn_speed_n = 1'b1; btn_clear_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_start", cmd_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_running", running, 0);
        chk("rst_speed", speed, 0);
        chk("rst_gen_count", gen_count, 0);
        chk("rst_cmd_op", cmd_op, 0);
        rst = 1'b0;

        // step held through reset must not fire
        repeat (10) @(negedge clk);
        chk("held_step_busy", busy, 0);
        btn_step_n = 1'b1;
        repeat (2) @(negedge clk);
        press(B_STEP, e);
        sb_push(1'b0, e + 1);
        repeat (8) @(negedge clk);
        chk("step_gen_count", gen_count, 1);

        // run at speed 0: period 32
        press(B_RUN, e);
        chk("run_on", running, 1);
        for (int k = 1; k <= 3; k++) sb_push(1'b0, e + 1 + 32 * k);
        repeat (103) @(negedge clk);
        chk("run_gen_count", gen_count, 4);

        // speed up to 3: period 4
        done_lat = 1;
        press(B_SPEED, e);
        chk("speed_1", speed, 1);
        @(negedge clk);
        press(B_SPEED, e);
        chk("speed_2", speed, 2);
        @(negedge clk);
        press(B_SPEED, e);
        chk("speed_3", speed, 3);
        for (int k = 0; k < 3; k++) sb_push(1'b0, e + 5 + 4 * k);
        repeat (14) @(negedge clk);
        press(B_RUN, e);
        chk("pause_running", running, 0);
        chk("fast_gen_count", gen_count, 7);

        // slow engine: extra ticks dropped, one gen pending
        done_lat = 20;
        repeat (2) @(negedge clk);
        press(B_RUN, e);
        sb_push(1'b0, e + 5);
        sb_push(1'b0, e + 27);
        repeat (25) @(negedge clk);
        chk("slow_busy_hold", busy, 1);
        chk("slow_gen_before_done", gen_count, 7);
        @(negedge clk);
        chk("slow_busy_done", busy, 0);
        chk("slow_gen_after_done", gen_count, 8);
        repeat (13) @(negedge clk);
        press(B_RUN, e);
        chk("slow_pause", running, 0);
        repeat (10) @(negedge clk);
        chk("slow_gen_final", gen_count, 9);
        chk("slow_idle", busy, 0);

        press(B_SPEED, e);
        chk("speed_wrap", speed, 0);

        // clear and step together: clear first, then gen
        done_lat = 3;
        repeat (2) @(negedge clk);
        press(B_CLEAR | B_STEP, e);
        sb_push(1'b1, e + 1);
        sb_push(1'b0, e + 6);
        repeat (5) @(negedge clk);
        chk("clr_step_gen_zero", gen_count, 0);
        repeat (7) @(negedge clk);
        chk("clr_step_gen_one", gen_count, 1);

        // clear while running and busy
        done_lat = 10;
        repeat (2) @(negedge clk);
        press(B_RUN, e);
        chk("run2_on", running, 1);
        sb_push(1'b0, e + 33);
        sb_push(1'b1, e + 45);
        repeat (35) @(negedge clk);
        press(B_CLEAR, e);
        chk("clr_busy_running", running, 0);
        chk("clr_busy_busy", busy, 1);
        repeat (14) @(negedge clk);
        chk("clr_busy_gen_mid", gen_count, 2);
        repeat (50) @(negedge clk);
        chk("clr_busy_gen_end", gen_count, 0);
        chk("clr_busy_running_end", running, 0);

        // run and clear in the same cycle
        done_lat = 3;
        press(B_RUN | B_CLEAR, e);
        chk("run_clr_running", running, 0);
        sb_push(1'b1, e + 1);
        repeat (8) @(negedge clk);
        chk("run_clr_gen", gen_count, 0);

        // reset mid-command, late done ignored
        done_lat = 10;
        press(B_STEP, e);
        sb_push(1'b0, e + 1);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        repeat (11) @(negedge clk);
        chk("post_rst_gen", gen_count, 0);
        chk("post_rst_busy", busy, 0);

        // step held for 35 cycles while paused
        done_lat = 3;
        repeat (2) @(negedge clk);
        e = cyc + 1;
        sb_push(1'b0, e + 1);
`ifdef GOL_STEP_REPEAT_EN
        for (int k = 1; k <= 3; k++) sb_push(1'b0, e + 1 + 10 * k);
`endif
        btn_step_n = 1'b0;
        repeat (35) @(negedge clk);
        btn_step_n = 1'b1;
        repeat (20) @(negedge clk);
`ifdef GOL_STEP_REPEAT_EN
        chk("hold_gen_count", gen_count, 4);
`else
        chk("hold_gen_count", gen_count, 1);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/life_run_controller.md
# life_run_controller

Sequencing controller between the debounced front-panel buttons and the Game of Life generation engine. Turns active-low debounced button levels into press events and runs a run/pause/step/clear/speed state machine. Issues single-outstanding start/done commands to the engine, either at a speed-selectable generation rate or on demand. Also keeps a generation counter for the display.

## Interface
- TICK_BASE, 1000000: base generation period in clk cycles; the actual period is TICK_BASE << (3 - speed).
- REPEAT_CYCLES, 4000000: step auto-repeat hold/interval in clk cycles; used only with GOL_STEP_REPEAT_EN.
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- btn_run_n  in  1  debounced run/pause button; low means pressed.
- btn_step_n  in  1  debounced single-step button; low means pressed.
- btn_speed_n  in  1  debounced speed-cycle button; low means pressed.
- btn_clear_n  in  1  debounced clear-board button; low means pressed.
- cmd_done  in  1  engine's one-cycle completion pulse for the outstanding command.
- cmd_start  out  1  one-cycle command issue pulse.
- cmd_op  out  1  command type; 0 = compute next generation, 1 = clear board. Valid while cmd_start is high and held until done.
- busy  out  1  high from cmd_start until the accepted cmd_done.
- running  out  1  auto-run enabled.
- speed  out  2  rate index; 0 is slowest, 3 is fastest.
- gen_count  out  16  number of completed generations since the last clear; wraps from 0xFFFF to 0.

## Operation
- Press detection: each button has a prev register, reset to 0 (treated as pressed). A press is input=0 with prev=1, and prev loads the input every cycle. A button held through reset therefore does not fire until it is released and pressed again.
- run press toggles running. On pause, the tick counter and pend_gen both clear.
- step press sets pend_gen only when running=0; it is ignored while running.
- speed press sets speed to speed+1, wrapping 3→0, and zeroes the tick counter.
- clear press sets pend_clr, forces running=0, and clears pend_gen.
- Tick counter (32-bit): counts only while running=1. When it reaches period-1 it returns to 0 and sets pend_gen. A tick that arrives with pend_gen already set is dropped, so at most one generation is pending.
- FSM states and transitions:
  - IDLE → ISSUE when pend_clr or pend_gen is set. pend_clr wins, so clear has priority over gen.
  - ISSUE: drive cmd_start=1 for one cycle, latch cmd_op, clear the chosen pending bit, then go to BUSY.
  - BUSY → IDLE on cmd_done.
- cmd_done handling: outside BUSY it is ignored. A done for a gen op increments gen_count; a done for a clear op zeroes gen_count.
- Presses and ticks during BUSY only set pending bits; they never abort the outstanding command.
- Simultaneous presses in one cycle are handled in this order: clear, run, speed, step. A clear in the same cycle as a run press leaves running=0.
- Reset values: cmd_start=0, cmd_op=0, busy=0, running=0, speed=0, gen_count=0, pending bits=0, counters=0, FSM=IDLE. Reset asserted mid-command returns to IDLE, and the engine's later cmd_done is ignored.

## Timing
- Press to command: the press is detected at edge N; ISSUE is registered at N+1, so cmd_start is high during cycle N+1→N+2. busy rises together with cmd_start.
- Done to next command: cmd_done sampled at edge M returns the FSM to IDLE and clears busy at M. The next cmd_start can be high from M+1, so back-to-back ops have a minimum spacing of cmd_done + 2 cycles.
- Tick to command: a tick at edge T gives cmd_start high from T+1 when idle.
- Generation rate while running and idle: one cmd_start every period cycles.
- gen_count updates on the same edge that accepts cmd_done.

## Configuration
- GOL_STEP_REPEAT_EN defined: while running=0 and btn_step_n is held low, a hold counter sets pend_gen after REPEAT_CYCLES cycles and every REPEAT_CYCLES cycles after that. Release or running=1 zeroes the hold counter.
- GOL_STEP_REPEAT_EN undefined: exactly one step per press, and the hold counter logic is absent.

## Test plan
- Reset with btn_step_n held low, then keep it low: no cmd_start. Release and press again: cmd_start with cmd_op=0, 1 cycle after the press edge.
- TICK_BASE=4, press run: at speed 0, cmd_start every 32 cycles, with engine done returned 3 cycles after start. Press speed three times: the period becomes 4 cycles. A fourth press wraps speed to 0.
- Running at period 4 with the engine holding done for 20 cycles: exactly one gen issued right after done, excess ticks dropped, gen_count increments by 1 per done.
- Press clear and step in the same cycle while paused and idle: cmd_op=1 is issued first, then cmd_op=0. gen_count goes 0 → 1.
- Press clear while running during BUSY: running=0, clear is issued after done, gen_count=0, and no further gens are issued.
- With GOL_STEP_REPEAT_EN and REPEAT_CYCLES=10, hold step for 35 cycles while paused: 1 + 3 cmd_start pulses. Without the macro: 1 pulse.
